// File: rtl/ahb_protocol_checker.sv
// Passive AHB-Lite protocol checker: burst tracking plus attribute/address/beat/boundary/alignment/size/response checks.
// Latency: violations sampled at edge N appear on err_* after edge N (one registered stage).
// Backpressure: none; HREADY=0 cycles only advance the response history, never the burst tracker.
module ahb_protocol_checker #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSELx,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [2:0]            HBURST,
    input  logic [2:0]            HSIZE,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic                  HRESP,
    input  logic                  clr,
    output logic                  err_valid,
    output logic [7:0]            err_vector,
    output logic [7:0]            err_sticky,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  burst_active,
    output logic [3:0]            beats_left
);

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_BUSY   = 2'd1;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    localparam logic [2:0] BR_SINGLE = 3'd0;
    localparam logic [2:0] BR_INCR   = 3'd1;

    localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);
    localparam logic [11:0]           DW_BITS = 12'(DATA_WIDTH);

    typedef enum logic [1:0] {ST_IDLE, ST_FIXED, ST_UNDEF} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   last_addr;
    logic [2:0]              last_burst;
    logic [2:0]              last_size;
    logic                    last_write;
    logic                    err_seen;
    logic                    resp_wait;

    logic                    accepted;
    logic                    is_nonseq;
    logic                    is_seq;
    logic                    is_busy;
    logic                    idle_rdy;
    logic [ADDR_WIDTH-1:0]   incr_addr;
    logic [ADDR_WIDTH-1:0]   wrap_len;
    logic [ADDR_WIDTH-1:0]   wrap_mask;
    logic [ADDR_WIDTH-1:0]   exp_addr;
    logic [ADDR_WIDTH-1:0]   align_mask;
    logic [11:0]             size_bits;
    logic                    attr_diff;
    logic [3:0]              init_beats;
    logic [7:0]              vec;

    assign accepted  = HREADY && HSELx && (HTRANS != TR_IDLE);
    assign is_nonseq = accepted && (HTRANS == TR_NONSEQ);
    assign is_seq    = accepted && (HTRANS == TR_SEQ);
    assign is_busy   = accepted && (HTRANS == TR_BUSY);
    assign idle_rdy  = HREADY && (HTRANS == TR_IDLE);

    // Expected SEQ address from the previous beat; wrap length is zero for non-wrapping bursts
    always_comb begin
        wrap_len = '0;
        case (last_burst)
            3'd2:    wrap_len = ADDR_WIDTH'(4);
            3'd4:    wrap_len = ADDR_WIDTH'(8);
            3'd6:    wrap_len = ADDR_WIDTH'(16);
            default: wrap_len = '0;
        endcase
        incr_addr = last_addr + (ONE << last_size);
        wrap_mask = (wrap_len << last_size) - ONE;
        exp_addr  = (wrap_len == '0) ? incr_addr
                                     : ((last_addr & ~wrap_mask) | (incr_addr & wrap_mask));
    end

    // Remaining SEQ beats after the NONSEQ of a fixed-length burst
    always_comb begin
        init_beats = 4'd15;
        case (HBURST)
            3'd2, 3'd3: init_beats = 4'd3;
            3'd4, 3'd5: init_beats = 4'd7;
            default:    init_beats = 4'd15;
        endcase
    end

    assign align_mask = (ONE << HSIZE) - ONE;
    assign size_bits  = 12'd8 << HSIZE;
    assign attr_diff  = (HBURST != last_burst) || (HSIZE != last_size) || (HWRITE != last_write);

    // Per-cycle violation map
    always_comb begin
        vec    = '0;
        vec[0] = (is_seq || is_busy) && attr_diff;
        vec[1] = is_seq && (HADDR != exp_addr);
        vec[2] = (is_seq || is_busy) && (state == ST_IDLE);
        vec[3] = (is_nonseq || idle_rdy) && (state == ST_FIXED) && (beats_left != 4'd0)
                 && !(err_seen || HRESP);
        vec[4] = is_seq && (HADDR[ADDR_WIDTH-1:10] != last_addr[ADDR_WIDTH-1:10]);
        vec[5] = (is_nonseq || is_seq) && ((HADDR & align_mask) != '0);
        vec[6] = (is_nonseq || is_seq) && (size_bits > DW_BITS);
        vec[7] = HRESP && HREADY && !resp_wait;
    end

    // Burst FSM: follows accepted NONSEQ/SEQ and ends on an idle bus cycle
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state        <= ST_IDLE;
            beats_left   <= 4'd0;
            burst_active <= 1'b0;
        end else if (is_nonseq) begin
            if (HBURST == BR_SINGLE) begin
                state        <= ST_IDLE;
                beats_left   <= 4'd0;
                burst_active <= 1'b0;
            end else if (HBURST == BR_INCR) begin
                state        <= ST_UNDEF;
                beats_left   <= 4'd0;
                burst_active <= 1'b1;
            end else begin
                state        <= ST_FIXED;
                beats_left   <= init_beats;
                burst_active <= 1'b1;
            end
        end else if (is_seq && (state == ST_FIXED)) begin
            beats_left <= beats_left - 4'd1;
            if (beats_left == 4'd1) begin
                state        <= ST_IDLE;
                burst_active <= 1'b0;
            end
        end else if (idle_rdy) begin
            state        <= ST_IDLE;
            beats_left   <= 4'd0;
            burst_active <= 1'b0;
        end
    end

    // Reference attributes of the most recent NONSEQ/SEQ beat
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            last_addr  <= '0;
            last_burst <= 3'd0;
            last_size  <= 3'd0;
            last_write <= 1'b0;
        end else if (is_nonseq || is_seq) begin
            last_addr  <= HADDR;
            last_burst <= HBURST;
            last_size  <= HSIZE;
            last_write <= HWRITE;
        end
    end

    // Response history: first ERROR cycle seen, and any ERROR since the burst started
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            resp_wait <= 1'b0;
            err_seen  <= 1'b0;
        end else begin
            resp_wait <= HRESP && !HREADY;
            err_seen  <= is_nonseq ? 1'b0 : (err_seen || HRESP);
        end
    end

    // Registered reporting: pulse, vector, sticky accumulation and saturating count
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            err_valid  <= 1'b0;
            err_vector <= 8'd0;
            err_sticky <= 8'd0;
            err_count  <= '0;
        end else begin
            err_valid  <= |vec;
            err_vector <= vec;
            err_sticky <= clr ? vec : (err_sticky | vec);
            if (clr) begin
                err_count <= CNT_WIDTH'(|vec);
            end else if ((|vec) && (err_count != '1)) begin
                err_count <= err_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/ahb_protocol_checker.md
# ahb_protocol_checker

Synthesisable AHB-Lite bus protocol checker, parametrised successor to the single HBURST-stability assertion on the AHB interface. It passively samples one manager/subordinate link and tracks burst state. It checks attribute stability, address sequencing (INCR and WRAP), beat count, 1 KB boundary, alignment, size and the two-cycle ERROR response. Violations are reported as registered flags, sticky bits and a saturating counter, so the checker works in both simulation and emulation/FPGA builds.

## Interface
- ADDR_WIDTH, 32, HADDR width (>= 11).
- DATA_WIDTH, 32, data bus width; 8/16/32/64/128/256/512/1024.
- CNT_WIDTH, 16, width of the violation counter.
- HCLK  input  1  bus clock; all logic on rising edge.
- HRESETn  input  1  reset, synchronous, active-low.
- HSELx  input  1  subordinate select.
- HADDR  input  ADDR_WIDTH  address.
- HBURST  input  3  burst type.
- HSIZE  input  3  transfer size.
- HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  input  1  direction.
- HREADY  input  1  transfer-complete / address-phase accept.
- HRESP  input  1  0=OKAY, 1=ERROR.
- clr  input  1  clears err_sticky and err_count.
- err_valid  output  1  one-cycle pulse: at least one violation detected in the previous cycle.
- err_vector  output  8  violations detected in the previous cycle (bit map below).
- err_sticky  output  8  OR-accumulation of err_vector since reset/clr.
- err_count  output  CNT_WIDTH  number of cycles with err_valid=1, saturating at all-ones.
- burst_active  output  1  a burst (fixed or INCR) is in progress.
- beats_left  output  4  remaining SEQ beats of the current fixed-length burst.

## Operation
- An address phase is accepted on a rising edge with HREADY=1, HSELx=1 and HTRANS!=IDLE. All address checks run only on accepted phases.
- Burst FSM states: IDLE, FIXED, UNDEF.
  - Accepted NONSEQ with HBURST=SINGLE, or HBURST=INCR, or a fixed burst type:
    - SINGLE -> IDLE.
    - INCR -> UNDEF.
    - INCR4/WRAP4 -> FIXED with beats_left=3.
    - INCR8/WRAP8 -> FIXED with beats_left=7.
    - INCR16/WRAP16 -> FIXED with beats_left=15.
  - The checker latches HADDR, HBURST, HSIZE and HWRITE on every accepted NONSEQ/SEQ.
  - Accepted SEQ in FIXED decrements beats_left; at 0 the FSM goes to IDLE.
  - Accepted BUSY leaves state and beats_left unchanged.
  - Accepted NONSEQ/IDLE (HREADY=1) ends UNDEF.
- err_vector bits:
  - [0] ATTR: SEQ/BUSY whose HBURST, HSIZE or HWRITE differs from the latched value.
  - [1] ADDR: SEQ address != expected. INCR: prev+(1<<HSIZE). WRAPn: (prev & ~(B-1)) | ((prev+(1<<HSIZE)) & (B-1)), with B=n<<HSIZE.
  - [2] NOBURST: SEQ or BUSY accepted while FSM is IDLE.
  - [3] BEATS: accepted NONSEQ or IDLE (HREADY=1) while FIXED with beats_left>0, unless an ERROR response occurred since the burst's NONSEQ.
  - [4] BOUND1K: SEQ whose HADDR[ADDR_WIDTH-1:10] differs from the latched address.
  - [5] ALIGN: accepted NONSEQ/SEQ with HADDR not aligned to 1<<HSIZE.
  - [6] SIZE: accepted NONSEQ/SEQ with (1<<HSIZE) > DATA_WIDTH/8.
  - [7] RESP: HRESP=1 with HREADY=1 whose preceding cycle was not HRESP=1 with HREADY=0. Evaluated every cycle, independent of HSELx.
- Multiple violations in one cycle set multiple bits, but err_count increments by 1.
- clr=1 with new violations in the same cycle:
  - err_sticky takes the new vector.
  - err_count becomes 1.
- The FSM still advances on a flagged transfer. After BEATS, the FSM follows the new NONSEQ.

## Timing
- Reset (HRESETn=0 at an edge) sets:
  - FSM=IDLE, beats_left=0, burst_active=0.
  - err_valid=0, err_vector=0, err_sticky=0, err_count=0.
  - The ERROR-seen and response-history flags are cleared.
- Reset mid-burst abandons the burst with no violation reported.
- All outputs are registered. A violation sampled at edge N is visible after edge N, i.e. 1-cycle latency. err_sticky and err_count update at the same edge.
- burst_active and beats_left reflect the FSM state after the accepting edge.
- HREADY=0 cycles: no address checks and no FSM change. Only RESP history is tracked.

## Test plan
- Reset mid-burst:
  - Stimulus: HRESETn=0 for 1 cycle while FIXED with beats_left=5.
  - Required response: all outputs 0 next cycle, then a fresh NONSEQ raises no violation.
- Legal INCR4:
  - Stimulus: HSIZE=2 at 0x100/104/108/10C, then a WRAP8 at 0x3C/20/24/28/2C/30/34/38, with BUSY and wait states inserted.
  - Required response: err_valid never 1; beats_left 3->0 and 7->0.
- HBURST change:
  - Stimulus: HBURST changes INCR8->INCR4 on beat 2.
  - Required response: err_vector=0x01 one cycle later; err_count=1; err_sticky=0x01.
- Early termination:
  - Stimulus: INCR4 terminated by NONSEQ after 2 beats.
  - Required response: err_vector=0x08.
  - Repeat with a preceding two-cycle ERROR response; required response: no violation.
- Boundary and alignment:
  - Stimulus: INCR SEQ 0x3FC->0x400.
  - Required response: err_vector=0x10.
  - Stimulus: NONSEQ HSIZE=2 at 0x102.
  - Required response: err_vector=0x20.
- Single-cycle ERROR and count handling:
  - Stimulus: HRESP=1 with HREADY=1 without the prior wait cycle.
  - Required response: err_vector=0x80.
  - Stimulus: clr in the same cycle as a new error.
  - Required response: err_count=1.
  - With CNT_WIDTH=2, five error cycles: err_count saturates at 3.
